multiply_matrix: RTL and testbench
==================================

Name: multiply_matrix

Overview:
- Clocked signed-integer matrix multiplier: mat_out = mat_a × mat_b.
- mat_a is SIZE_A×SIZE_B, mat_b is SIZE_B×SIZE_C, mat_out is SIZE_A×SIZE_C.
- Used by the decomposition datapath, e.g. timed matrix × initial vector (SIZE_C=1).
- Operands are latched on a start pulse; one inner-dimension term is accumulated per cycle; the registered result is presented with a done pulse.

Parameters:
SIZE_A, 8, rows of mat_a and of mat_out
SIZE_B, 8, inner dimension (columns of mat_a, rows of mat_b); must be ≥1
SIZE_C, 1, columns of mat_b and of mat_out

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous reset, active-high
start  input  1  request; sampled only when busy=0
mat_a  input  integer[SIZE_A][SIZE_B]  left operand, 32-bit signed elements
mat_b  input  integer[SIZE_B][SIZE_C]  right operand, 32-bit signed elements
mat_out  output  integer[SIZE_A][SIZE_C]  registered product, 32-bit signed elements
busy  output  1  high while an operation is in progress
done  output  1  single-cycle pulse when mat_out has been updated

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset (rst=1 at a clk edge):
  - mat_out all 0, busy=0, done=0.
  - Inner counter k=0, accumulators 0.
  - Reset overrides start and aborts any operation in progress.
- States: IDLE (busy=0) and RUN (busy=1).
- IDLE:
  - start=1 at edge T: latch mat_a and mat_b into internal copies, clear all accumulators, k=0, busy=1.
  - Input changes after edge T do not affect the result.
- RUN, edges T+1 … T+SIZE_B: for every i<SIZE_A and j<SIZE_C, acc[i][j] += a[i][k]*b[k][j], then k increments.
- At edge T+SIZE_B, i.e. the last term k=SIZE_B-1:
  - mat_out <= final sums.
  - done <= 1 for exactly one cycle.
  - busy <= 0; state returns to IDLE.
- Latency: done is high in the cycle following edge T+SIZE_B (SIZE_B cycles after the start edge).
- start while busy=1 is ignored; no queueing.
- start asserted in the cycle where done=1 is accepted, since busy is already 0; back-to-back throughput is one result per SIZE_B+1 cycles.
- mat_out holds its last value between operations and while a new operation runs. It changes only at completion or reset.
- done=0 in every cycle except the completion pulse.
- Arithmetic:
  - Each product is a 32×32 signed multiply keeping the low 32 bits.
  - Accumulation is 32-bit two's-complement and wraps modulo 2^32 with no saturation and no overflow flag.
- SIZE_B=1: the single term is accumulated at edge T+1, and done is high the cycle after that.

Decomposition:
- Shared package (matrix_pkg):
  - typedef elem_t = 32-bit signed (int).
  - Constant ELEM_W=32.
  - Matrix typedefs reused by the other decomposition blocks.
- Natural sub-module multiply_matrix_mac:
  - One lane per (i,j); holds the accumulator.
  - Inputs: clear, enable, a, b.
  - Instantiated SIZE_A×SIZE_C times by generate.
- Top level holds the operand latches, the k counter and the IDLE/RUN control.

Test Plan:
- Reset: hold rst=1 for 2 cycles with start=1 -> mat_out all 0, busy=0, done=0, no operation starts.
- SIZE_A=SIZE_B=SIZE_C=2, a={{1,2},{3,4}}, b={{5,6},{7,8}}, one start pulse -> done exactly 2 cycles after the start edge, mat_out={{19,22},{43,50}}, busy high for 2 cycles.
- Defaults 8×8×1: a[i][j]=i+j, b[k][0]=1 for all k; change the inputs to 0 one cycle after start -> mat_out[i][0]=8i+28 (28…84), done 8 cycles after start.
- Signs and wrap:
  - a=-3, b=7 (1×1×1) -> mat_out=-21.
  - a=65536, b=65536 -> mat_out=0 (wraps).
  - a=2147483647, b=2 -> mat_out=-2.
- start held high continuously (2×2×2 case) -> a new operation begins the cycle done is high; done pulses every 3 cycles; pulses during busy are ignored.
- rst=1 one cycle mid-operation -> mat_out=0, busy=0, and no done pulse follows; a following start produces the correct result.

Source files
------------

// File: rtl/matrix_pkg.sv
// Shared element/matrix types and the multiply-accumulate helper
// used by the matrix decomposition datapath.
package matrix_pkg;

    localparam int ELEM_W     = 32;
    localparam int DEF_SIZE_A = 8;
    localparam int DEF_SIZE_B = 8;
    localparam int DEF_SIZE_C = 1;

    typedef logic signed [ELEM_W-1:0] elem_t;
    typedef elem_t mat_ab_t [DEF_SIZE_A][DEF_SIZE_B];
    typedef elem_t mat_bc_t [DEF_SIZE_B][DEF_SIZE_C];
    typedef elem_t mat_ac_t [DEF_SIZE_A][DEF_SIZE_C];

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } mm_state_t;

    // Low 32 bits of the product added with two's-complement wrap.
    function automatic elem_t mac_term(input elem_t acc, input elem_t a, input elem_t b);
        elem_t prod;
        prod = a * b;
        return acc + prod;
    endfunction

endpackage

// File: rtl/multiply_matrix_mac.sv
// One accumulator lane of the matrix multiplier; o_sum is the running
// total including the term currently presented on i_a/i_b.
module multiply_matrix_mac
    import matrix_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_clear,
    input  logic                     i_en,
    input  logic signed [ELEM_W-1:0] i_a,
    input  logic signed [ELEM_W-1:0] i_b,
    output logic signed [ELEM_W-1:0] o_sum
);

    logic signed [ELEM_W-1:0] r_acc;

    assign o_sum = mac_term(r_acc, i_a, i_b);

    // Accumulator register: cleared on reset or new operation, adds one term per enabled cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc <= '0;
        end else if (i_clear) begin
            r_acc <= '0;
        end else if (i_en) begin
            r_acc <= o_sum;
        end else begin
            r_acc <= r_acc;
        end
    end

endmodule

// File: rtl/multiply_matrix.sv
// Sequential signed matrix multiplier mat_out = mat_a x mat_b, one inner
// term per cycle across SIZE_A x SIZE_C parallel accumulator lanes.
module multiply_matrix
    import matrix_pkg::*;
#(
    parameter int SIZE_A = 8,
    parameter int SIZE_B = 8,
    parameter int SIZE_C = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic signed [ELEM_W-1:0] mat_a   [SIZE_A][SIZE_B],
    input  logic signed [ELEM_W-1:0] mat_b   [SIZE_B][SIZE_C],
    output logic signed [ELEM_W-1:0] mat_out [SIZE_A][SIZE_C],
    output logic                     busy,
    output logic                     done
);

    localparam int K_W = (SIZE_B > 1) ? $clog2(SIZE_B) : 1;
    localparam logic [K_W-1:0] K_LAST = K_W'(SIZE_B - 1);

    mm_state_t      r_state;
    mm_state_t      w_state_next;
    logic [K_W-1:0] r_k;
    logic           r_busy;
    logic           r_done;
    logic           w_load;
    logic           w_step;
    logic           w_last;

    elem_t r_a   [SIZE_A][SIZE_B];
    elem_t r_b   [SIZE_B][SIZE_C];
    elem_t w_sum [SIZE_A][SIZE_C];

    assign busy = r_busy;
    assign done = r_done;

    // Next-state and control strobes for the IDLE/RUN sequencer.
    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_step       = 1'b0;
        w_last       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_load       = 1'b1;
                    w_state_next = ST_RUN;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_RUN: begin
                w_step = 1'b1;
                if (r_k == K_LAST) begin
                    w_last       = 1'b1;
                    w_state_next = ST_IDLE;
                end else begin
                    w_state_next = ST_RUN;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // State, inner counter and status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_k     <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_busy  <= (w_state_next == ST_RUN);
            r_done  <= w_last;
            if (w_load || w_last) begin
                r_k <= '0;
            end else if (w_step) begin
                r_k <= r_k + K_W'(1);
            end else begin
                r_k <= r_k;
            end
        end
    end

    // Operand snapshot taken on the accepted start, so later input changes are ignored.
    always_ff @(posedge clk) begin
        for (int i = 0; i < SIZE_A; i++) begin
            for (int k = 0; k < SIZE_B; k++) begin
                if (rst) begin
                    r_a[i][k] <= '0;
                end else if (w_load) begin
                    r_a[i][k] <= mat_a[i][k];
                end else begin
                    r_a[i][k] <= r_a[i][k];
                end
            end
        end
        for (int k = 0; k < SIZE_B; k++) begin
            for (int j = 0; j < SIZE_C; j++) begin
                if (rst) begin
                    r_b[k][j] <= '0;
                end else if (w_load) begin
                    r_b[k][j] <= mat_b[k][j];
                end else begin
                    r_b[k][j] <= r_b[k][j];
                end
            end
        end
    end

    // Result register: updated only with the final sums or cleared by reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < SIZE_A; i++) begin
            for (int j = 0; j < SIZE_C; j++) begin
                if (rst) begin
                    mat_out[i][j] <= '0;
                end else if (w_last) begin
                    mat_out[i][j] <= w_sum[i][j];
                end else begin
                    mat_out[i][j] <= mat_out[i][j];
                end
            end
        end
    end

    for (genvar gi = 0; gi < SIZE_A; gi++) begin : g_row
        for (genvar gj = 0; gj < SIZE_C; gj++) begin : g_col
            multiply_matrix_mac u_mac (
                .clk     (clk),
                .rst     (rst),
                .i_clear (w_load),
                .i_en    (w_step),
                .i_a     (r_a[gi][r_k]),
                .i_b     (r_b[r_k][gj]),
                .o_sum   (w_sum[gi][gj])
            );
        end
    end

endmodule

// File: tb/tb_multiply_matrix.sv
// Scoreboard bench for multiply_matrix: 2x2x2, default 8x8x1 and 1x1x1
// instances driven with directed vectors; monitors check every done pulse.
module tb_multiply_matrix;
    import matrix_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic start2, start8, start1;
    logic busy2, busy8, busy1;
    logic done2, done8, done1;
    elem_t a2 [2][2];
    elem_t b2 [2][2];
    elem_t o2 [2][2];
    elem_t a8 [8][8];
    elem_t b8 [8][1];
    elem_t o8 [8][1];
    elem_t a1 [1][1];
    elem_t b1 [1][1];
    elem_t o1 [1][1];

    multiply_matrix #(.SIZE_A(2), .SIZE_B(2), .SIZE_C(2)) u_dut2 (
        .clk(clk), .rst(rst), .start(start2), .mat_a(a2), .mat_b(b2),
        .mat_out(o2), .busy(busy2), .done(done2));
    multiply_matrix u_dut8 (
        .clk(clk), .rst(rst), .start(start8), .mat_a(a8), .mat_b(b8),
        .mat_out(o8), .busy(busy8), .done(done8));
    multiply_matrix #(.SIZE_A(1), .SIZE_B(1), .SIZE_C(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .mat_a(a1), .mat_b(b1),
        .mat_out(o1), .busy(busy1), .done(done1));

    typedef struct {
        time          t;
        logic [255:0] v;
    } exp_t;

    exp_t q2[$];
    exp_t q8[$];
    exp_t q1[$];
    exp_t e2, e8, e1;
    int   n_cmp = 0;
    int   n_err = 0;
    time  t0;
    logic [255:0] ev;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [255:0] pk2(input elem_t m [2][2]);
        logic [255:0] p;
        p = '0;
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++)
                p[32*(i*2+j) +: 32] = m[i][j];
        return p;
    endfunction

    function automatic logic [255:0] pk8(input elem_t m [8][1]);
        logic [255:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) p[32*i +: 32] = m[i][0];
        return p;
    endfunction

    function automatic logic [255:0] mk2(input elem_t e00, input elem_t e01,
                                         input elem_t e10, input elem_t e11);
        logic [255:0] p;
        p = '0;
        p[31:0] = e00;
        p[63:32] = e01;
        p[95:64] = e10;
        p[127:96] = e11;
        return p;
    endfunction

    // Monitors: every done pulse must match the oldest expected result and its time.
    always @(negedge clk) begin
        if (done2) begin
            if (q2.size() == 0) chk("u2_unexpected_done", 256'd1, 256'd0);
            else begin
                e2 = q2.pop_front();
                chk("u2_done_time", 256'($time), 256'(e2.t));
                chk("u2_mat_out", pk2(o2), e2.v);
            end
        end
        if (done8) begin
            if (q8.size() == 0) chk("u8_unexpected_done", 256'd1, 256'd0);
            else begin
                e8 = q8.pop_front();
                chk("u8_done_time", 256'($time), 256'(e8.t));
                chk("u8_mat_out", pk8(o8), e8.v);
            end
        end
        if (done1) begin
            if (q1.size() == 0) chk("u1_unexpected_done", 256'd1, 256'd0);
            else begin
                e1 = q1.pop_front();
                chk("u1_done_time", 256'($time), 256'(e1.t));
                chk("u1_mat_out", 256'(o1[0][0]) & 256'hFFFF_FFFF, e1.v);
            end
        end
    end

    task automatic go2(input logic [255:0] v);
        @(negedge clk);
        start2 = 1'b1;
        @(posedge clk);
        q2.push_back('{t: $time + 25, v: v});
        @(negedge clk);
        start2 = 1'b0;
    endtask

    task automatic go8(input logic [255:0] v);
        @(negedge clk);
        start8 = 1'b1;
        @(posedge clk);
        q8.push_back('{t: $time + 85, v: v});
        @(negedge clk);
        start8 = 1'b0;
    endtask

    task automatic go1(input elem_t a, input elem_t b, input logic [31:0] r);
        @(negedge clk);
        a1[0][0] = a;
        b1[0][0] = b;
        start1 = 1'b1;
        @(posedge clk);
        q1.push_back('{t: $time + 15, v: 256'(r)});
        @(negedge clk);
        start1 = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        start2 = 1'b1; start8 = 1'b1; start1 = 1'b1;
        a2 = '{'{32'sd1, 32'sd2}, '{32'sd3, 32'sd4}};
        b2 = '{'{32'sd5, 32'sd6}, '{32'sd7, 32'sd8}};
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 8; j++) a8[i][j] = elem_t'(i + j);
            b8[i][0] = 32'sd1;
        end
        a1[0][0] = 32'sd5;
        b1[0][0] = 32'sd5;

        // Reset held with start high
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_u2_out", pk2(o2), 256'd0);
        chk("rst_u8_out", pk8(o8), 256'd0);
        chk("rst_u1_out", 256'(o1[0][0]) & 256'hFFFF_FFFF, 256'd0);
        chk("rst_flags", {busy2, busy8, busy1, done2, done8, done1}, 256'd0);
        rst = 1'b0;
        start2 = 1'b0; start8 = 1'b0; start1 = 1'b0;
        @(negedge clk);
        chk("no_start_after_rst", {busy2, busy8, busy1}, 256'd0);

        // 2x2x2 single operation
        go2(mk2(32'sd19, 32'sd22, 32'sd43, 32'sd50));
        chk("u2_busy_c1", busy2, 256'd1);
        @(negedge clk);
        chk("u2_busy_c2", {busy2, done2}, 256'd2);
        @(negedge clk);
        chk("u2_idle_at_done", {busy2, done2}, 256'd1);
        @(negedge clk);

        // 8x8x1 defaults, inputs zeroed right after the start edge
        ev = '0;
        for (int i = 0; i < 8; i++) ev[32*i +: 32] = 32'(8 * i + 28);
        go8(ev);
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 8; j++) a8[i][j] = 32'sd0;
            b8[i][0] = 32'sd0;
        end
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            chk("u8_busy_run", {busy8, done8}, 256'd2);
        end
        @(negedge clk);
        chk("u8_idle_at_done", {busy8, done8}, 256'd1);

        // 1x1x1 signs and wrap
        go1(-32'sd3, 32'sd7, 32'hFFFF_FFEB);
        go1(32'sd65536, 32'sd65536, 32'h0000_0000);
        go1(32'sd2147483647, 32'sd2, 32'hFFFF_FFFE);

        // 2x2x2 with start held high: restarts on each done cycle
        @(negedge clk);
        a2 = '{'{-32'sd1, 32'sd2}, '{32'sd3, 32'sd0}};
        b2 = '{'{32'sd2, 32'sd1}, '{-32'sd4, 32'sd5}};
        start2 = 1'b1;
        @(posedge clk);
        t0 = $time;
        q2.push_back('{t: t0 + 25, v: mk2(-32'sd10, 32'sd9, 32'sd6, 32'sd3)});
        q2.push_back('{t: t0 + 55, v: mk2(32'sd19, 32'sd22, 32'sd43, 32'sd50)});
        q2.push_back('{t: t0 + 85, v: mk2(32'sd19, 32'sd22, 32'sd43, 32'sd50)});
        @(negedge clk);
        a2 = '{'{32'sd1, 32'sd2}, '{32'sd3, 32'sd4}};
        b2 = '{'{32'sd5, 32'sd6}, '{32'sd7, 32'sd8}};
        repeat (3) @(negedge clk);
        chk("u2_out_held", pk2(o2), mk2(-32'sd10, 32'sd9, 32'sd6, 32'sd3));
        repeat (3) @(posedge clk);
        @(negedge clk);
        start2 = 1'b0;
        repeat (4) @(negedge clk);

        // Reset mid-operation on the 8x8x1 instance
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 8; j++) a8[i][j] = elem_t'(i + j);
            b8[i][0] = 32'sd1;
        end
        go8(256'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        void'(q8.pop_back());
        chk("u8_midrst_out", pk8(o8), 256'd0);
        chk("u8_midrst_flags", {busy8, done8}, 256'd0);
        repeat (10) @(negedge clk);
        for (int i = 0; i < 8; i++) b8[i][0] = 32'sd2;
        ev = '0;
        for (int i = 0; i < 8; i++) ev[32*i +: 32] = 32'(16 * i + 56);
        go8(ev);
        repeat (10) @(negedge clk);

        chk("pending_results", 256'(q2.size() + q8.size() + q1.size()), 256'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
